// File: rtl/cla_nibble_serial_addsub_if.sv
// Request/response bundle between the ALU sequencer and the nibble-serial add/sub engine.
interface cla_nibble_serial_addsub_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             cout;
   logic             v;

   modport master (
      output start, sub, cin, x, y,
      input  ready, done, out, cout, v
   );

   modport slave (
      input  start, sub, cin, x, y,
      output ready, done, out, cout, v
   );
endinterface

// File: rtl/cla_nibble_serial_addsub.sv
// WIDTH-bit add/subtract built from one 4-bit carry-look-ahead slice reused
// once per nibble, LSB nibble first; done pulses once the top nibble lands.
module cla_nibble_serial_addsub #(
   parameter int unsigned WIDTH = 16
) (
   input logic                       clk,
   input logic                       rst,
   cla_nibble_serial_addsub_if.slave bus
);
   localparam int unsigned N     = WIDTH / 4;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
         $error("cla_nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] x_q, y_q, out_q;
   logic             sub_q, carry_q, cout_q, v_q, ready_q, done_q;
   logic [CNT_W-1:0] cnt;
   logic             accept_c, step_c, last_c;
   logic [3:0]       a_c, b_c, g_c, p_c, sum_c;
   logic [4:0]       c_c;

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.out   = out_q;
   assign bus.cout  = cout_q;
   assign bus.v     = v_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      step_c     = 1'b0;
      last_c     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept_c   = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step_c = 1'b1;
            if (cnt == LAST) begin
               last_c     = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs registered from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         ready_q <= (state_next == IDLE);
         done_q  <= (state_next == DONE);
      end
   end

   // Shared 4-bit carry-look-ahead slice on the current nibble.
   always_comb begin
      a_c    = x_q[{cnt, 2'b00} +: 4];
      b_c    = y_q[{cnt, 2'b00} +: 4] ^ {4{sub_q}};
      g_c    = a_c & b_c;
      p_c    = a_c ^ b_c;
      c_c[0] = carry_q;
      c_c[1] = g_c[0] | (p_c[0] & c_c[0]);
      c_c[2] = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & c_c[0]);
      c_c[3] = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
             | (p_c[2] & p_c[1] & p_c[0] & c_c[0]);
      c_c[4] = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
             | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
             | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & c_c[0]);
      sum_c  = p_c ^ c_c[3:0];
   end

   // Operand capture, per-nibble result write-back and final flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q     <= '0;
         y_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cnt     <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         v_q     <= 1'b0;
      end else if (accept_c) begin
         x_q     <= bus.x;
         y_q     <= bus.y;
         sub_q   <= bus.sub;
         carry_q <= bus.cin ^ bus.sub;
         cnt     <= '0;
      end else if (step_c) begin
         out_q[{cnt, 2'b00} +: 4] <= sum_c;
         carry_q                  <= c_c[4];
         cnt                      <= last_c ? '0 : cnt + CNT_W'(1);
         if (last_c) begin
            cout_q <= c_c[4] ^ sub_q;
            v_q    <= c_c[4] ^ c_c[3];
         end
      end
   end
endmodule

// File: tb/tb_cla_nibble_serial_addsub.sv
// Directed checks of the nibble-serial add/sub engine at WIDTH=16 and WIDTH=4.
module tb_cla_nibble_serial_addsub;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] prev16 = '0;

   always #5 clk = ~clk;

   cla_nibble_serial_addsub_if #(.WIDTH(16)) bus16 ();
   cla_nibble_serial_addsub_if #(.WIDTH(4))  bus4 ();

   cla_nibble_serial_addsub #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   cla_nibble_serial_addsub #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference {v, cout, out} for a 16-bit op.
   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                           input logic s, input logic c);
      logic [16:0] r;
      int          sr;
      if (!s) begin
         r  = {1'b0, a} + {1'b0, b} + 17'(c);
         sr = int'($signed(a)) + int'($signed(b)) + int'(c);
      end else begin
         r  = {1'b0, a} - {1'b0, b} - 17'(c);
         sr = int'($signed(a)) - int'($signed(b)) - int'(c);
      end
      return {(sr > 32767 || sr < -32768), r[16], r[15:0]};
   endfunction

   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic c,
                       input logic [15:0] eo, input logic ec, input logic ev);
      int   cyc;
      logic seen;
      @(negedge clk);
      check({tag, " ready_idle"}, 32'(bus16.ready), 32'd1);
      bus16.start = 1'b1; bus16.x = a; bus16.y = b; bus16.sub = s; bus16.cin = c;
      @(negedge clk);
      bus16.start = 1'b0;
      bus16.x = 16'($urandom); bus16.y = 16'($urandom);
      bus16.sub = 1'($urandom); bus16.cin = 1'($urandom);
      check({tag, " ready_busy"}, 32'(bus16.ready), 32'd0);
      check({tag, " out_hold"}, 32'(bus16.out), 32'(prev16));
      cyc  = 1;
      seen = bus16.done;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         seen = bus16.done;
      end
      check({tag, " latency"}, 32'(cyc), 32'd5);
      check({tag, " out"}, 32'(bus16.out), 32'(eo));
      check({tag, " cout"}, 32'(bus16.cout), 32'(ec));
      check({tag, " v"}, 32'(bus16.v), 32'(ev));
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(bus16.done), 32'd0);
      check({tag, " ready_back"}, 32'(bus16.ready), 32'd1);
      prev16 = eo;
   endtask

   task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic s, input logic c,
                      input logic [3:0] eo, input logic ec, input logic ev);
      int   cyc;
      logic seen;
      @(negedge clk);
      bus4.start = 1'b1; bus4.x = a; bus4.y = b; bus4.sub = s; bus4.cin = c;
      @(negedge clk);
      bus4.start = 1'b0;
      cyc  = 1;
      seen = bus4.done;
      while (!seen && cyc < 10) begin
         @(negedge clk);
         cyc++;
         seen = bus4.done;
      end
      check({tag, " latency"}, 32'(cyc), 32'd2);
      check({tag, " out"}, 32'(bus4.out), 32'(eo));
      check({tag, " cout"}, 32'(bus4.cout), 32'(ec));
      check({tag, " v"}, 32'(bus4.v), 32'(ev));
   endtask

   initial begin
      int   cyc, rdy, dcount;
      logic [17:0] m;
      logic [15:0] ra, rb;
      logic        rs, rc;

      rst = 1'b1;
      bus16.start = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.x = '0; bus16.y = '0;
      bus4.start  = 1'b0; bus4.sub  = 1'b0; bus4.cin  = 1'b0; bus4.x  = '0; bus4.y  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst ready", 32'(bus16.ready), 32'd1);
      check("rst done", 32'(bus16.done), 32'd0);
      check("rst out", 32'(bus16.out), 32'd0);
      check("rst cout", 32'(bus16.cout), 32'd0);
      check("rst v", 32'(bus16.v), 32'd0);
      check("rst4 ready", 32'(bus4.ready), 32'd1);

      // Hand-computed 16-bit vectors.
      op16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("sub_borrow",16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      op16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      op16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("sub_bin",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
      op16("add_ripple",16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
      op16("add_plain", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      op16("add_carry", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);

      // Abort mid-RUN: no done, reset values restored.
      @(negedge clk);
      bus16.start = 1'b1; bus16.x = 16'h1111; bus16.y = 16'h1111; bus16.sub = 1'b0; bus16.cin = 1'b0;
      @(negedge clk);
      bus16.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort ready", 32'(bus16.ready), 32'd1);
      check("abort out", 32'(bus16.out), 32'd0);
      check("abort cout", 32'(bus16.cout), 32'd0);
      check("abort done", 32'(bus16.done), 32'd0);
      dcount = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus16.done) dcount++;
      end
      check("abort no_done", 32'(dcount), 32'd0);
      prev16 = '0;

      // Reset beats start in the same cycle.
      rst = 1'b1; bus16.start = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus16.start = 1'b0;
      check("rst_over_start ready", 32'(bus16.ready), 32'd1);
      @(negedge clk);
      check("rst_over_start stay", 32'(bus16.ready), 32'd1);

      // start held high: one op every N+2 cycles, ready high only in IDLE.
      bus16.start = 1'b1; bus16.x = 16'h0001; bus16.y = 16'h0001; bus16.sub = 1'b0; bus16.cin = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus16.done && cyc < 20);
      check("b2b first_done", 32'(bus16.done), 32'd1);
      for (int k = 0; k < 2; k++) begin
         cyc = 0; rdy = 0;
         do begin
            @(negedge clk);
            cyc++;
            if (bus16.ready) rdy++;
         end while (!bus16.done && cyc < 20);
         if (k == 1) bus16.start = 1'b0;
         check("b2b period", 32'(cyc), 32'd6);
         check("b2b ready_cycles", 32'(rdy), 32'd1);
         check("b2b out", 32'(bus16.out), 32'h0002);
      end
      @(negedge clk);
      @(negedge clk);
      check("b2b stop", 32'(bus16.ready), 32'd1);
      prev16 = 16'h0002;

      // WIDTH=4 degenerates to a single CLA step.
      op4("w4_add_ovf", 4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1);
      op4("w4_sub_bor", 4'h0, 4'h1, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
      op4("w4_add_wrap",4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      op4("w4_sub_ovf", 4'h8, 4'h1, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1);
      op4("w4_sub_bin", 4'h5, 4'h3, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);

      // Broader sweep against the arithmetic reference.
      for (int i = 0; i < 1200; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rs = 1'(i); rc = 1'(i >> 1);
         m  = model16(ra, rb, rs, rc);
         op16("sweep", ra, rb, rs, rc, m[15:0], m[16], m[17]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
